iot_byte_serializer: RTL and testbench

- Transmit-side counterpart of the IoT filter datapath.
- Accepts 128-bit data words over a valid/ready interface and buffers them in a small FIFO.
- Serializes each word into 16 bytes, MSB first, paced by the consumer's per-byte enable.
- Counts words into rounds and flags the last byte of each word and the end of each round, so filter blocks downstream see the same framing they expect on their input.

---
 rtl/iot_byte_serializer.sv | 161 ++++++++++++++++
 tb/tb_iot_byte_serializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_byte_serializer.sv
// iot_byte_serializer: buffers DATA_W-bit words in a small FIFO and sends each
// one as DATA_W/8 bytes, MSB first, paced by the consumer's in_en. Framing
// outputs mark the last byte of every word and the end of every round.
//
// Handshakes: a word is pushed on any rising edge where wr_valid & wr_ready;
// wr_ready depends only on registered state (and rst), never on wr_valid.
// A byte is transferred on any rising edge where byte_valid is high; byte_valid
// is in_en qualified by the SEND state, so the consumer may stall indefinitely
// and iot_in holds its value for the whole stall.
module iot_byte_serializer #(
    parameter int DATA_W          = 128,
    parameter int DEPTH           = 4,
    parameter int WORDS_PER_ROUND = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               in_en,
    output logic [7:0]                         iot_in,
    output logic                               byte_valid,
    output logic                               last_byte,
    output logic                               round_done,
    output logic [$clog2(WORDS_PER_ROUND)-1:0] word_cnt,
    output logic [$clog2(DEPTH):0]             fifo_level,
    output logic                               busy,
    output logic [1:0]                         state_dbg
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = $clog2(BYTES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WC_W  = $clog2(WORDS_PER_ROUND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   shifter_q, shifter_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
    logic                round_done_q, round_done_d;
    logic [DATA_W-1:0]   fifo_mem [DEPTH];

    logic push;
    logic pop;
    logic xfer;
    logic last_xfer;

    // Handshake decode: ready comes from the registered level only, no pop bypass
    always_comb begin
        wr_ready  = !rst && (level_q < LVL_W'(DEPTH));
        push      = wr_valid && wr_ready;
        pop       = (state_q == ST_LOAD);
        xfer      = (state_q == ST_SEND) && in_en;
        last_xfer = xfer && (byte_cnt_q == BC_W'(BYTES - 1));
    end

    // Next-state logic for FIFO pointers, shifter, counters and the FSM
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        shifter_d    = shifter_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        round_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shifter_d  = fifo_mem[rd_ptr_q];
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    shifter_d  = {shifter_q[DATA_W-9:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                end
                if (last_xfer) begin
                    // Word counter wraps naturally: WORDS_PER_ROUND is a power of two
                    word_cnt_d   = word_cnt_q + WC_W'(1);
                    round_done_d = (word_cnt_q == WC_W'(WORDS_PER_ROUND - 1));
                    state_d      = (level_q != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register: reset discards the partial word and every buffered word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            shifter_q    <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            shifter_q    <= shifter_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            round_done_q <= round_done_d;
        end
    end

    // FIFO storage: payload only, so no reset; push is already blocked during rst
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Output decode: byte lane is forced to zero outside SEND
    always_comb begin
        iot_in     = (state_q == ST_SEND) ? shifter_q[DATA_W-1 -: 8] : 8'h00;
        byte_valid = xfer;
        last_byte  = last_xfer;
        round_done = round_done_q;
        word_cnt   = word_cnt_q;
        fifo_level = level_q;
        busy       = (state_q != ST_IDLE) || (level_q != '0);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_iot_byte_serializer.sv
// Testbench for iot_byte_serializer: reset checks, a per-cycle vector table for
// a single word, directed corner sequences, and a randomized run scored against
// a byte-queue reference model.
module tb_iot_byte_serializer;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam int WPR    = 8;
  localparam logic [127:0] W1 = 128'h00112233445566778899AABBCCDDEEFF;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              in_en = 1'b0;
  logic [7:0]        iot_in;
  logic              byte_valid;
  logic              last_byte;
  logic              round_done;
  logic [2:0]        word_cnt;
  logic [2:0]        fifo_level;
  logic              busy;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  iot_byte_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WORDS_PER_ROUND(WPR)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .in_en(in_en), .iot_in(iot_in), .byte_valid(byte_valid), .last_byte(last_byte),
    .round_done(round_done), .word_cnt(word_cnt), .fifo_level(fifo_level), .busy(busy),
    .state_dbg(state_dbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int tests  = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int bytes_sent;
  int words_done;
  int words_in;
  logic round_pend;

  // last sampled DUT values (taken at the falling edge inside step)
  logic       s_bv, s_last, s_ready, s_busy, s_rd;
  logic [7:0] s_byte;
  logic [1:0] s_state;
  logic [2:0] s_level, s_wc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    bytes_sent = 0;
    words_done = 0;
    words_in   = 0;
    round_pend = 1'b0;
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge against the
  // model, account for any accepted word, then advance past the rising edge.
  task automatic step(input logic wv, input logic [127:0] wd, input logic ie, output logic acc);
    logic rp_next;
    wr_valid = wv;
    wr_data  = wd;
    in_en    = ie;
    @(negedge clk);
    s_bv = byte_valid; s_last = last_byte; s_ready = wr_ready; s_busy = busy;
    s_rd = round_done; s_byte = iot_in; s_state = state_dbg; s_level = fifo_level;
    s_wc = word_cnt;
    rp_next = 1'b0;
    chk("round_done", round_done, round_pend);
    chk("word_cnt", word_cnt, words_done % WPR);
    if (!ie) chk("byte_valid_without_en", byte_valid, 1'b0);
    if (state_dbg == 2'd2) begin
      if (exp_q.size() == 0) chk("send_with_nothing_queued", exp_q.size(), 1);
      else chk("iot_in_current", iot_in, exp_q[0]);
    end else begin
      chk("iot_in_outside_send", iot_in, 8'h00);
    end
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", byte_valid, 1'b0);
      end else begin
        chk("byte", iot_in, exp_q.pop_front());
        chk("last_byte", last_byte, (bytes_sent % 16) == 15);
        bytes_sent++;
        if (bytes_sent % 16 == 0) begin
          words_done++;
          rp_next = (words_done % WPR) == 0;
        end
      end
    end else begin
      chk("last_byte_no_transfer", last_byte, 1'b0);
    end
    acc = wv && wr_ready;
    if (acc) begin
      for (int i = 0; i < 16; i++) exp_q.push_back(wd[127 - 8*i -: 8]);
      words_in++;
    end
    chk("capacity", (words_in - words_done) <= DEPTH + 1, 1'b1);
    round_pend = rp_next;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; in_en = 1'b0;
    @(negedge clk);
    chk("wr_ready_in_reset", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain(input int maxc, input string nm);
    logic acc;
    for (int c = 0; c < maxc; c++) begin
      step(1'b0, '0, 1'b1, acc);
      if (exp_q.size() == 0 && !s_busy) break;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_busy"}, s_busy, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wv;
    logic       ie;
    logic       exp_bv;
    logic [7:0] exp_byte;
    logic       exp_last;
    logic       exp_busy;
    logic [2:0] exp_level;
    logic [2:0] exp_wc;
    logic [1:0] exp_state;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic bv, input logic [7:0] b,
                              input logic last, input logic bsy, input logic [2:0] lvl,
                              input logic [2:0] wc, input logic [1:0] st);
    vec_t v;
    v.wv = wv; v.ie = 1'b1; v.exp_bv = bv; v.exp_byte = b; v.exp_last = last;
    v.exp_busy = bsy; v.exp_level = lvl; v.exp_wc = wc; v.exp_state = st;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[20];
    logic acc;
    logic [127:0] tw[10];
    int k, nbv, nlast, cyc, nrd, rd_cyc;
    int last_t[$];
    logic [127:0] wa, wb;

    // push cycle, IDLE with level 1, LOAD, 16 bytes, then IDLE with word_cnt 1
    vecs[0] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
    vecs[1] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 3'd0, 2'd0);
    vecs[2] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 3'd0, 2'd1);
    for (int j = 0; j < 16; j++)
      vecs[3 + j] = mk(1'b0, 1'b1, 8'(17 * j), j == 15, 1'b1, 3'd0, 3'd0, 2'd2);
    vecs[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd1, 2'd0);

    @(posedge clk);
    #1;
    do_reset();

    // post-reset outputs
    @(negedge clk);
    chk("rst_iot_in", iot_in, 8'h00);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_last_byte", last_byte, 1'b0);
    chk("rst_round_done", round_done, 1'b0);
    chk("rst_word_cnt", word_cnt, 3'd0);
    chk("rst_fifo_level", fifo_level, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_state", state_dbg, 2'd0);
    @(posedge clk);
    #1;

    // 1: single word, table driven
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].wv, W1, vecs[i].ie, acc);
      chk($sformatf("t1_bv[%0d]", i), s_bv, vecs[i].exp_bv);
      if (vecs[i].exp_bv) chk($sformatf("t1_byte[%0d]", i), s_byte, vecs[i].exp_byte);
      chk($sformatf("t1_last[%0d]", i), s_last, vecs[i].exp_last);
      chk($sformatf("t1_busy[%0d]", i), s_busy, vecs[i].exp_busy);
      chk($sformatf("t1_level[%0d]", i), s_level, vecs[i].exp_level);
      chk($sformatf("t1_wc[%0d]", i), s_wc, vecs[i].exp_wc);
      chk($sformatf("t1_state[%0d]", i), s_state, vecs[i].exp_state);
    end

    // 2: same word with in_en toggling
    step(1'b1, W1, 1'b1, acc);
    nbv = 0; nlast = 0;
    for (int c = 0; c < 80; c++) begin
      step(1'b0, '0, (c % 2) == 0, acc);
      if (s_bv) nbv++;
      if (s_last) nlast++;
      if (!s_busy && exp_q.size() == 0) break;
    end
    chk("t2_byte_count", nbv, 16);
    chk("t2_last_count", nlast, 1);
    chk("t2_drained", exp_q.size(), 0);

    // 3: capacity with consumer stalled, then release
    do_reset();
    for (int i = 0; i < 10; i++) tw[i] = rand_word();
    k = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b1, tw[k], 1'b0, acc);
      if (acc) k++;
    end
    chk("t3_accepted", k, 5);
    step(1'b0, '0, 1'b0, acc);
    chk("t3_level_full", s_level, 3'd4);
    chk("t3_ready_full", s_ready, 1'b0);
    for (int c = 0; c < 120; c++) begin
      step(1'b0, '0, 1'b1, acc);
      if (c <= 19) chk($sformatf("t3_ready[%0d]", c), s_ready, c >= 17);
      if (!s_busy && exp_q.size() == 0) break;
    end
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_words", words_done, 5);

    // 4: nine words back to back, round boundary
    do_reset();
    for (int i = 0; i < 9; i++) tw[i] = rand_word();
    k = 0; cyc = 0; nrd = 0; rd_cyc = -1;
    last_t.delete();
    for (int c = 0; c < 250; c++) begin
      step(k < 9, (k < 9) ? tw[k] : 128'd0, 1'b1, acc);
      if (acc) k++;
      if (s_bv && s_last) last_t.push_back(cyc);
      if (s_rd) begin nrd++; rd_cyc = cyc; end
      cyc++;
      if (k == 9 && exp_q.size() == 0 && !s_busy) break;
    end
    chk("t4_last_count", last_t.size(), 9);
    for (int i = 1; i < last_t.size(); i++)
      chk($sformatf("t4_spacing[%0d]", i), last_t[i] - last_t[i-1], 17);
    chk("t4_round_pulses", nrd, 1);
    if (last_t.size() >= 8) chk("t4_round_timing", rd_cyc, last_t[7] + 1);
    step(1'b0, '0, 1'b1, acc);
    chk("t4_word_cnt_end", s_wc, 3'd1);

    // 5: reset mid-word with two words queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b1, acc);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, '0, 1'b1, acc);
      if (bytes_sent == 5) break;
    end
    chk("t5_bytes_before_rst", bytes_sent, 5);
    rst = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
    chk("t5_queued_before_rst", fifo_level, 3'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t5_bv_after_rst", byte_valid, 1'b0);
    chk("t5_level_after_rst", fifo_level, 3'd0);
    chk("t5_busy_after_rst", busy, 1'b0);
    chk("t5_wc_after_rst", word_cnt, 3'd0);
    @(posedge clk);
    #1;
    step(1'b1, W1, 1'b1, acc);
    drain(40, "t5");

    // 6: push in the same cycle as the final byte, FIFO empty
    wa = rand_word();
    wb = rand_word();
    step(1'b1, wa, 1'b1, acc);
    for (int c = 1; c < 18; c++) step(1'b0, '0, 1'b1, acc);
    step(1'b1, wb, 1'b1, acc);
    chk("t6_final_byte", s_last, 1'b1);
    chk("t6_final_level", s_level, 3'd0);
    step(1'b0, '0, 1'b1, acc);
    chk("t6_idle_state", s_state, 2'd0);
    chk("t6_idle_bv", s_bv, 1'b0);
    step(1'b0, '0, 1'b1, acc);
    chk("t6_load_state", s_state, 2'd1);
    step(1'b0, '0, 1'b1, acc);
    chk("t6_first_bv", s_bv, 1'b1);
    chk("t6_first_byte", s_byte, wb[127:120]);
    drain(40, "t6");

    // randomized traffic against the byte-queue model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 1) == 1, rand_word(), $urandom_range(0, 3) != 0, acc);
    end
    drain(200, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
